// File: rtl/radar_sim_pkg.sv
// Shared definitions for the radar simulation blocks: tracker state encoding
// and common widths.
package radar_sim_pkg;

  typedef enum logic [1:0] {
    S_UNCAL    = 2'd0,
    S_WAIT_ARP = 2'd1,
    S_TRACK    = 2'd2
  } track_state_e;

  localparam int REV_ERR_CNT_W = 8;
  localparam int DATA_WIDTH_DEF = 32;

endpackage

// File: rtl/radar_sat_counter.sv
// Saturating up-counter with synchronous clear.
// When clear and increment arrive together, the counter restarts at 1.
module radar_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] base;

  // Next count: optional clear, then increment unless already all-ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc && (base != '1)) cnt_d = base + WIDTH'(1);
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/radar_position_tracker.sv
// Tracks antenna azimuth (ACPs since ARP), range time (us since trigger) and
// triggers per revolution, and checks each revolution against the calibrated
// ACP count, dropping sync after SYNC_TOL consecutive bad revolutions.
module radar_position_tracker
  import radar_sim_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SYNC_TOL   = 3
) (
  input  logic                     S_AXIS_ACLK,
  input  logic                     S_AXIS_ARESET,
  input  logic                     RADAR_ARP_PE,
  input  logic                     RADAR_ACP_PE,
  input  logic                     RADAR_TRIG_PE,
  input  logic                     USEC_PE,
  input  logic                     CALIBRATED,
  input  logic [DATA_WIDTH-1:0]    RADAR_ACP_CNT,
  output logic [DATA_WIDTH-1:0]    AZIMUTH,
  output logic [DATA_WIDTH-1:0]    RANGE_US,
  output logic [DATA_WIDTH-1:0]    TRIG_IDX,
  output logic                     SYNCED,
  output logic                     ACP_OVERRUN,
  output logic                     REV_ERR,
  output logic [REV_ERR_CNT_W-1:0] REV_ERR_CNT
);

  localparam logic [3:0] SYNC_TOL_V = 4'(SYNC_TOL);

  track_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] acp_seen_q, acp_seen_d;
  logic [DATA_WIDTH-1:0] azimuth_q, azimuth_d;
  logic                  overrun_q, overrun_d;
  logic [3:0]            bad_q, bad_d;
  logic                  rev_err_q, rev_err_d;
  logic                  trig_clr, trig_inc;
  logic [DATA_WIDTH:0]   rev_count;
  logic [DATA_WIDTH-1:0] limit;
  logic [3:0]            bad_inc;

  // Next-state, revolution check and azimuth clamp.
  always_comb begin
    state_d    = state_q;
    acp_seen_d = acp_seen_q;
    azimuth_d  = azimuth_q;
    overrun_d  = overrun_q;
    bad_d      = bad_q;
    rev_err_d  = 1'b0;
    trig_clr   = 1'b0;
    trig_inc   = 1'b0;
    // A coincident ACP is the last pulse of the ending revolution.
    rev_count  = {1'b0, acp_seen_q} + (DATA_WIDTH+1)'(RADAR_ACP_PE);
    limit      = RADAR_ACP_CNT - DATA_WIDTH'(1);
    bad_inc    = bad_q + 4'd1;

    if (!CALIBRATED) begin
      state_d    = S_UNCAL;
      acp_seen_d = '0;
      azimuth_d  = '0;
      overrun_d  = 1'b0;
      bad_d      = '0;
      trig_clr   = 1'b1;
    end else begin
      case (state_q)
        S_UNCAL: state_d = S_WAIT_ARP;
        S_WAIT_ARP: begin
          // A zero ACP count is unusable; never lock onto it.
          if (RADAR_ARP_PE && (RADAR_ACP_CNT != '0)) begin
            state_d    = S_TRACK;
            acp_seen_d = '0;
            azimuth_d  = '0;
            overrun_d  = 1'b0;
            bad_d      = '0;
            trig_clr   = 1'b1;
            trig_inc   = RADAR_TRIG_PE;
          end
        end
        S_TRACK: begin
          if (RADAR_ACP_CNT == '0) begin
            state_d    = S_WAIT_ARP;
            acp_seen_d = '0;
            azimuth_d  = '0;
            overrun_d  = 1'b0;
            trig_clr   = 1'b1;
          end else if (RADAR_ARP_PE) begin
            if (rev_count != {1'b0, RADAR_ACP_CNT}) begin
              rev_err_d = 1'b1;
              bad_d     = bad_inc;
              if (bad_inc >= SYNC_TOL_V) state_d = S_WAIT_ARP;
            end else begin
              bad_d = '0;
            end
            acp_seen_d = '0;
            azimuth_d  = '0;
            overrun_d  = 1'b0;
            // A trigger on the ARP cycle is the first of the new revolution.
            trig_clr   = 1'b1;
            trig_inc   = RADAR_TRIG_PE;
          end else begin
            if (RADAR_ACP_PE) begin
              acp_seen_d = acp_seen_q + DATA_WIDTH'(1);
              if (acp_seen_d > limit) begin
                azimuth_d = limit;
                overrun_d = 1'b1;
              end else begin
                azimuth_d = acp_seen_d;
              end
            end
            trig_inc = RADAR_TRIG_PE;
          end
        end
        default: state_d = S_UNCAL;
      endcase
    end
  end

  // Tracker state registers.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= S_UNCAL;
      acp_seen_q <= '0;
      azimuth_q  <= '0;
      overrun_q  <= 1'b0;
      bad_q      <= '0;
      rev_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acp_seen_q <= acp_seen_d;
      azimuth_q  <= azimuth_d;
      overrun_q  <= overrun_d;
      bad_q      <= bad_d;
      rev_err_q  <= rev_err_d;
    end
  end

  // Range time: trigger restarts it, otherwise the 1 us tick advances it.
  radar_sat_counter #(.WIDTH(DATA_WIDTH)) u_range (
    .clk (S_AXIS_ACLK),
    .rst (S_AXIS_ARESET),
    .clr (RADAR_TRIG_PE),
    .inc (USEC_PE && !RADAR_TRIG_PE),
    .cnt (RANGE_US)
  );

  radar_sat_counter #(.WIDTH(DATA_WIDTH)) u_trig_idx (
    .clk (S_AXIS_ACLK),
    .rst (S_AXIS_ARESET),
    .clr (trig_clr),
    .inc (trig_inc),
    .cnt (TRIG_IDX)
  );

  radar_sat_counter #(.WIDTH(REV_ERR_CNT_W)) u_rev_err_cnt (
    .clk (S_AXIS_ACLK),
    .rst (S_AXIS_ARESET),
    .clr (1'b0),
    .inc (rev_err_d),
    .cnt (REV_ERR_CNT)
  );

  assign AZIMUTH     = azimuth_q;
  assign SYNCED      = (state_q == S_TRACK);
  assign ACP_OVERRUN = overrun_q;
  assign REV_ERR     = rev_err_q;

endmodule

// File: tb/tb_radar_position_tracker.sv
// Directed bench for radar_position_tracker (DATA_WIDTH=8, SYNC_TOL=3).
// Stimulus pushes hand-computed expectations into a queue; a monitor pops
// one entry after each clock edge and compares the selected outputs.
module tb_radar_position_tracker;

  localparam int DW = 8;

  localparam logic [3:0] N = 4'b0000, U = 4'b0001, T = 4'b0010,
                         A = 4'b0100, R = 4'b1000;

  localparam logic [6:0] M_AZ = 7'd1, M_RNG = 7'd2, M_TIDX = 7'd4, M_SYNC = 7'd8,
                         M_OVR = 7'd16, M_ERR = 7'd32, M_CNT = 7'd64, M_ALL = 7'd127;

  typedef struct {
    string          name;
    logic [6:0]     care;
    logic [DW-1:0]  az;
    logic [DW-1:0]  rng;
    logic [DW-1:0]  tidx;
    logic           sy;
    logic           ov;
    logic           er;
    logic [7:0]     cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          arp, acp, trig, usec, cal;
  logic [DW-1:0] acp_cnt;
  logic [DW-1:0] azimuth, range_us, trig_idx;
  logic          synced, overrun, rev_err;
  logic [7:0]    rev_err_cnt;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  radar_position_tracker #(.DATA_WIDTH(DW), .SYNC_TOL(3)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .RADAR_ARP_PE  (arp),
    .RADAR_ACP_PE  (acp),
    .RADAR_TRIG_PE (trig),
    .USEC_PE       (usec),
    .CALIBRATED    (cal),
    .RADAR_ACP_CNT (acp_cnt),
    .AZIMUTH       (azimuth),
    .RANGE_US      (range_us),
    .TRIG_IDX      (trig_idx),
    .SYNCED        (synced),
    .ACP_OVERRUN   (overrun),
    .REV_ERR       (rev_err),
    .REV_ERR_CNT   (rev_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t ex(input string n, input logic [6:0] care,
                              input logic [DW-1:0] az, input logic [DW-1:0] rng,
                              input logic [DW-1:0] tidx, input logic sy, input logic ov,
                              input logic er, input logic [7:0] cnt);
    exp_t e;
    e.name = n; e.care = care; e.az = az; e.rng = rng; e.tidx = tidx;
    e.sy = sy; e.ov = ov; e.er = er; e.cnt = cnt;
    return e;
  endfunction

  // Drive one cycle of pulses from a falling edge; optionally queue the
  // expected outputs visible after the following rising edge.
  task automatic cyc(input logic [3:0] p, input bit chk, input exp_t e);
    {arp, acp, trig, usec} = p;
    if (chk) exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.care[0]) check({e.name, ".az"},   32'(azimuth),     32'(e.az));
        if (e.care[1]) check({e.name, ".rng"},  32'(range_us),    32'(e.rng));
        if (e.care[2]) check({e.name, ".tidx"}, 32'(trig_idx),    32'(e.tidx));
        if (e.care[3]) check({e.name, ".sync"}, 32'(synced),      32'(e.sy));
        if (e.care[4]) check({e.name, ".ovr"},  32'(overrun),     32'(e.ov));
        if (e.care[5]) check({e.name, ".err"},  32'(rev_err),     32'(e.er));
        if (e.care[6]) check({e.name, ".cnt"},  32'(rev_err_cnt), 32'(e.cnt));
      end
    end
  end

  exp_t nc;

  initial begin
    nc = ex("none", 7'd0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; cal = 1'b0; acp_cnt = 8'd5;
    arp = 1'b0; acp = 1'b0; trig = 1'b0; usec = 1'b0;
    @(negedge clk);

    // Reset overrides active pulses; everything reads zero.
    for (int i = 0; i < 3; i++) cyc(R | A | T | U, 1, ex("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    // Uncalibrated: range still runs, no sync, ARP ignored.
    cyc(U, 1, ex("uncal_rng", M_RNG | M_SYNC | M_AZ, 0, 1, 0, 0, 0, 0, 0));
    cyc(R | A, 1, ex("uncal_arp", M_SYNC | M_AZ | M_ERR, 0, 0, 0, 0, 0, 0, 0));

    // Lock and track a good revolution of 5 ACPs.
    cal = 1'b1;
    cyc(N, 0, nc);
    cyc(N, 1, ex("wait_arp", M_SYNC, 0, 0, 0, 0, 0, 0, 0));
    cyc(R, 1, ex("lock", M_AZ | M_TIDX | M_SYNC | M_ERR, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      cyc(A, 1, ex("az_step", M_AZ | M_SYNC | M_OVR | M_ERR, 8'(i), 0, 0, 1, 0, 0, 0));
    cyc(R | A, 1, ex("rev_ok", M_AZ | M_SYNC | M_OVR | M_ERR | M_CNT, 0, 0, 0, 1, 0, 0, 0));
    cyc(N, 1, ex("rev_ok_next", M_ERR | M_CNT, 0, 0, 0, 1, 0, 0, 0));

    // Range: trigger, 7 ticks, trigger wins over coincident tick, saturation.
    cyc(T, 1, ex("trig", M_RNG | M_TIDX, 0, 0, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 7; i++)
      cyc(U, (i == 7), ex("rng7", M_RNG | M_TIDX, 0, 7, 1, 1, 0, 0, 0));
    cyc(T | U, 1, ex("trig_usec", M_RNG | M_TIDX, 0, 0, 2, 1, 0, 0, 0));
    for (int i = 1; i <= 258; i++)
      cyc(U, (i == 254 || i >= 255), ex("rng_sat", M_RNG, 0, (i >= 255) ? 8'd255 : 8'd254, 0, 1, 0, 0, 0));

    // Overrun: 7 ACPs against a count of 5.
    for (int i = 1; i <= 7; i++)
      cyc(A, 1, ex("ovr_step", M_AZ | M_OVR | M_ERR, (i < 5) ? 8'(i) : 8'd4, 0, 0, 1, (i >= 5), 0, 0));
    cyc(R | T, 1, ex("ovr_arp", M_AZ | M_OVR | M_ERR | M_CNT | M_TIDX | M_SYNC, 0, 0, 1, 1, 0, 1, 1));
    cyc(N, 1, ex("ovr_after", M_ERR | M_CNT | M_OVR, 0, 0, 0, 1, 0, 0, 1));

    // Good revolution clears the bad-revolution count.
    for (int i = 0; i < 4; i++) cyc(A, 0, nc);
    cyc(R | A, 1, ex("good_rev", M_ERR | M_CNT | M_SYNC, 0, 0, 0, 1, 0, 0, 1));

    // Loss of sync: three short revolutions in a row.
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 3; i++) cyc(A, 0, nc);
      cyc(R, 1, ex("short_rev", M_ERR | M_CNT | M_SYNC | M_AZ, 0, 0, 0, (k < 3), 0, 1, 8'(1 + k)));
      cyc(N, 1, ex("short_rev_next", M_ERR | M_SYNC, 0, 0, 0, (k < 3), 0, 0, 0));
    end
    // ACPs while waiting are ignored; next ARP re-locks without a check.
    cyc(A, 1, ex("wait_acp", M_AZ | M_SYNC, 0, 0, 0, 0, 0, 0, 0));
    cyc(R, 1, ex("relock", M_AZ | M_SYNC | M_ERR | M_CNT, 0, 0, 0, 1, 0, 0, 4));
    cyc(A, 1, ex("relock_az1", M_AZ, 1, 0, 0, 1, 0, 0, 0));
    cyc(A, 1, ex("relock_az2", M_AZ, 2, 0, 0, 1, 0, 0, 0));
    cyc(T, 1, ex("relock_trig", M_TIDX | M_AZ, 2, 0, 1, 1, 0, 0, 0));

    // Calibration drop mid-revolution.
    cal = 1'b0;
    cyc(A | T, 1, ex("cal_drop", M_AZ | M_TIDX | M_SYNC | M_OVR | M_ERR | M_CNT, 0, 0, 0, 0, 0, 0, 4));
    cyc(R, 1, ex("cal_drop_hold", M_AZ | M_TIDX | M_SYNC | M_CNT, 0, 0, 0, 0, 0, 0, 4));

    // Zero ACP count while calibrated never locks.
    cal = 1'b1; acp_cnt = 8'd0;
    cyc(N, 0, nc);
    cyc(R, 1, ex("zero_cnt_arp", M_SYNC | M_ERR, 0, 0, 0, 0, 0, 0, 0));
    cyc(R | A, 1, ex("zero_cnt_arp2", M_SYNC | M_AZ | M_CNT, 0, 0, 0, 0, 0, 0, 4));
    cyc(N, 0, nc);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
